qbus_dma_arb: RTL and testbench

QBUS_DMA_ARB -- requirements
Module: qbus_dma_arb

---
 rtl/qbus_dma_arb.sv | 126 ++++++++++++
 tb/tb_qbus_dma_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/qbus_dma_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qbus_dma_arb : Q-bus DMA arbiter between the CPU and the DMR/DMG/SACK    |
// |                daisy chain, with grant timeout and a CPU fairness slot.  |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module qbus_dma_arb #(
  parameter int ARB_TMO  = 64,
  parameter int CPU_SLOT = 4
) (
  input  logic pin_clk,
  input  logic pin_rst,
  input  logic pin_dmr_n,
  input  logic pin_sack_n,
  output logic pin_dmgo_n,
  input  logic cpu_sync,
  output logic cpu_hold,
  output logic dma_act,
  output logic tmo
);

  localparam int c_TW = $clog2(ARB_TMO);
  localparam int c_SW = $clog2(CPU_SLOT + 1);
  localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(ARB_TMO - 1);
  localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(CPU_SLOT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUS = 3'd1,
    ST_GRANT    = 3'd2,
    ST_ACK      = 3'd3,
    ST_RECOVER  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_tmo_hit;
  logic              r_dmr_meta;
  logic              r_dmr_s;
  logic              r_sack_meta;
  logic              r_sack_s;
  logic [c_TW-1:0]   r_timer;
  logic [c_SW-1:0]   r_slot;

  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      r_dmr_meta  <= 1'b0;
      r_dmr_s     <= 1'b0;
      r_sack_meta <= 1'b0;
      r_sack_s    <= 1'b0;
    end else begin
      r_dmr_meta  <= ~pin_dmr_n;
      r_dmr_s     <= r_dmr_meta;
      r_sack_meta <= ~pin_sack_n;
      r_sack_s    <= r_sack_meta;
    end
  end

  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A RECOVER slot that ends with DMR still asserted goes straight to
  // WAIT_BUS, so the CPU gets exactly CPU_SLOT unheld cycles.
  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_dmr_s) w_next = ST_WAIT_BUS;
      end
      ST_WAIT_BUS: begin
        if (!r_dmr_s)       w_next = ST_IDLE;
        else if (!cpu_sync) w_next = ST_GRANT;
      end
      ST_GRANT: begin
        if (r_sack_s) begin
          w_next = ST_ACK;
        end else if (r_timer == c_TMO_LAST) begin
          w_next    = ST_IDLE;
          w_tmo_hit = 1'b1;
        end else if (!r_dmr_s) begin
          w_next = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!r_sack_s) w_next = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (r_slot == c_SLOT_LAST) w_next = r_dmr_s ? ST_WAIT_BUS : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counters only advance while staying in their state, so they stop at the last value.
  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      r_timer <= '0;
      r_slot  <= '0;
    end else begin
      r_timer <= (r_state == ST_GRANT && w_next == ST_GRANT) ? r_timer + 1'b1 : '0;
      r_slot  <= (r_state == ST_RECOVER && w_next == ST_RECOVER) ? r_slot + 1'b1 : '0;
    end
  end

  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      pin_dmgo_n <= 1'b1;
      cpu_hold   <= 1'b0;
      dma_act    <= 1'b0;
      tmo        <= 1'b0;
    end else begin
      pin_dmgo_n <= (w_next != ST_GRANT);
      cpu_hold   <= (w_next == ST_WAIT_BUS) || (w_next == ST_GRANT) || (w_next == ST_ACK);
      dma_act    <= (w_next == ST_ACK);
      tmo        <= w_tmo_hit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qbus_dma_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qbus_dma_arb : output-change scoreboard bench for qbus_dma_arb.       |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_qbus_dma_arb;

  logic clk = 1'b0;
  logic rst;
  logic dmr_n;
  logic sack_n;
  logic cpu_sync;
  logic dmgo_n;
  logic cpu_hold;
  logic dma_act;
  logic tmo;

  int cyc    = 0;
  int t0     = 0;
  int checks = 0;
  int errors = 0;

  // Expected output vector order: {pin_dmgo_n, cpu_hold, dma_act, tmo}
  typedef struct {
    string      name;
    logic [3:0] vec;
    int         cyc;
  } ev_t;

  ev_t q[$];

  qbus_dma_arb #(.ARB_TMO(8), .CPU_SLOT(4)) dut (
    .pin_clk    (clk),
    .pin_rst    (rst),
    .pin_dmr_n  (dmr_n),
    .pin_sack_n (sack_n),
    .pin_dmgo_n (dmgo_n),
    .cpu_sync   (cpu_sync),
    .cpu_hold   (cpu_hold),
    .dma_act    (dma_act),
    .tmo        (tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic begin_scn();
    t0 = cyc;
  endtask

  task automatic at(input int k);
    while (cyc < t0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string n, input logic [3:0] v, input int k);
    ev_t e;
    e.name = n;
    e.vec  = v;
    e.cyc  = t0 + k;
    q.push_back(e);
  endtask

  task automatic check_now(input string n, input logic [3:0] v);
    logic [3:0] cur;
    cur = {dmgo_n, cpu_hold, dma_act, tmo};
    checks++;
    if (cur !== v) begin
      errors++;
      $display("FAIL %s: outputs=%b required=%b", n, cur, v);
    end
  endtask

  // Monitor: every change of the output vector must match the next queued event.
  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    ev_t        e;
    prev = 4'b1000;
    forever begin
      @(negedge clk);
      cur = {dmgo_n, cpu_hold, dma_act, tmo};
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: outputs=%b at cycle %0d, required %b unchanged",
                   cur, cyc - t0, prev);
        end else begin
          e = q.pop_front();
          if (cur !== e.vec || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s: outputs=%b at cycle %0d, required %b at cycle %0d",
                     e.name, cur, cyc - t0, e.vec, e.cyc - t0);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    dmr_n    = 1'b1;
    sack_n   = 1'b1;
    cpu_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", 4'b1000);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Idle request, full tenure, CPU slot, persistent DMR regrant, withdrawal in GRANT
    begin_scn();
    push_exp("idle_req_hold",     4'b1100, 3);
    push_exp("idle_req_grant",    4'b0100, 4);
    push_exp("tenure_ack",        4'b1110, 9);
    push_exp("tenure_recover",    4'b1000, 29);
    push_exp("regrant_hold",      4'b1100, 33);
    push_exp("regrant_grant",     4'b0100, 34);
    push_exp("withdraw_in_grant", 4'b1000, 38);
    dmr_n = 1'b0;
    at(6);  sack_n = 1'b0;
    at(26); sack_n = 1'b1;
    at(35); dmr_n  = 1'b1;
    at(45);

    // Busy CPU holds off the grant until SYNC drops
    begin_scn();
    push_exp("busy_hold",  4'b1100, 3);
    push_exp("busy_grant", 4'b0100, 11);
    push_exp("busy_idle",  4'b1000, 15);
    dmr_n = 1'b0; cpu_sync = 1'b1;
    at(10); cpu_sync = 1'b0;
    at(12); dmr_n = 1'b1;
    at(20);

    // Timeout with ARB_TMO=8; DMR withdrawal lands in the timeout cycle and loses
    begin_scn();
    push_exp("tmo_hold",    4'b1100, 3);
    push_exp("tmo_grant",   4'b0100, 4);
    push_exp("tmo_pulse",   4'b1001, 12);
    push_exp("tmo_pulse_end", 4'b1000, 13);
    dmr_n = 1'b0;
    at(9); dmr_n = 1'b1;
    at(20);

    // DMR withdrawn while waiting for the CPU: no grant
    begin_scn();
    push_exp("wait_hold",     4'b1100, 3);
    push_exp("wait_withdraw", 4'b1000, 7);
    dmr_n = 1'b0; cpu_sync = 1'b1;
    at(4);  dmr_n = 1'b1;
    at(10); cpu_sync = 1'b0;
    at(16);

    // SACK arrives in the same cycle as the timeout: ACK wins, no tmo
    begin_scn();
    push_exp("race_hold",    4'b1100, 3);
    push_exp("race_grant",   4'b0100, 4);
    push_exp("race_ack",     4'b1110, 12);
    push_exp("race_recover", 4'b1000, 17);
    dmr_n = 1'b0;
    at(9);  sack_n = 1'b0;
    at(14); sack_n = 1'b1; dmr_n = 1'b1;
    at(26);

    // Reset during ACK releases the bus at once; DMR must resynchronize afterwards
    begin_scn();
    push_exp("rst_hold",      4'b1100, 3);
    push_exp("rst_grant",     4'b0100, 4);
    push_exp("rst_ack",       4'b1110, 8);
    push_exp("rst_release",   4'b1000, 10);
    push_exp("rst_re_hold",   4'b1100, 15);
    push_exp("rst_re_grant",  4'b0100, 16);
    push_exp("rst_re_idle",   4'b1000, 20);
    dmr_n = 1'b0;
    at(5); sack_n = 1'b0;
    at(10);
    #1;
    rst = 1'b1;
    #1;
    check_now("reset_in_ack_same_cycle", 4'b1000);
    sack_n = 1'b1;
    at(12); rst   = 1'b0;
    at(17); dmr_n = 1'b1;
    at(26);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL events_pending: outstanding=%0d required=0 (next %s)", q.size(), q[0].name);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
